// File: rtl/key_event_decoder_pkg.sv
// key_evt_pkg: shared FSM state encoding and sizing helpers for key_event_decoder.
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        HELD   = 3'd2,
        WAIT2  = 3'd3,
        DONE   = 3'd4
    } key_fsm_t;

    function automatic int cpm(input int freq);
        return freq / 1000;
    endfunction

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_event_decoder_tick.sv
// ms_tick_gen: one-cycle tick marking the last cycle of each millisecond since clr.
module ms_tick_gen #(
    parameter int CPM = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (CPM > 1) ? $clog2(CPM) : 1;

    logic [W-1:0] r_cnt;

    assign tick = (r_cnt == W'(CPM - 1));

    // The clr cycle itself counts as the first cycle of the new millisecond.
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= W'((CPM > 1) ? 1 : 0);
        else
            r_cnt <= tick ? '0 : r_cnt + W'(1);
    end

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into short/long/double-click pulses.
// Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int LONG_MS     = 1000,
    parameter int DCLICK_MS   = 300,
    parameter int REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic key_repeat,
    output logic busy
);

    localparam int CPM = cpm(CLK_FREQ_HZ);
    localparam int MSW = cnt_w(LONG_MS, DCLICK_MS, REPEAT_MS);

    key_fsm_t       r_state;
    logic [MSW-1:0] r_ms;
    logic           r_short, r_long, r_dbl, r_busy;
    logic           w_press, w_release, w_tick, w_long_done, w_win_done, w_clr;

    assign w_press     = key_flag & ~key_state;
    assign w_release   = key_flag & key_state;
    assign w_long_done = (r_state == PRESS1) && w_tick && (r_ms == MSW'(LONG_MS - 1));
    assign w_win_done  = (r_state == WAIT2) && w_tick && (r_ms == MSW'(DCLICK_MS - 1));

    // Any state change restarts the timebase so every deadline is cycle exact.
    assign w_clr = ((r_state == IDLE)   && w_press)
                 | ((r_state == PRESS1) && (w_release || w_long_done))
                 | ((r_state == HELD)   && w_release)
                 | ((r_state == WAIT2)  && (w_press || w_win_done))
                 | ((r_state == DONE)   && w_release);

    ms_tick_gen #(.CPM(CPM)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst || w_clr)
            r_ms <= '0;
        else if (w_tick)
            r_ms <= r_ms + MSW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_dbl   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_dbl   <= 1'b0;
            case (r_state)
                IDLE: if (w_press) begin
                    r_state <= PRESS1;
                    r_busy  <= 1'b1;
                end
                PRESS1: if (w_long_done) begin
                    r_long  <= 1'b1;
                    r_state <= w_release ? IDLE : HELD;
                    r_busy  <= ~w_release;
                end else if (w_release) begin
                    r_state <= WAIT2;
                end
                HELD: if (w_release) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                // A second press beats a window expiring in the same cycle.
                WAIT2: if (w_press) begin
                    r_dbl   <= 1'b1;
                    r_state <= DONE;
                end else if (w_win_done) begin
                    r_short <= 1'b1;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                DONE: if (w_release) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RPC = REPEAT_MS * CPM;
    localparam int RW  = (RPC > 1) ? $clog2(RPC) : 1;

    logic [RW-1:0] r_rep;
    logic          r_key_repeat;
    logic          w_rep;

    // Counts from the long_press cycle, so the first repeat lands REPEAT_MS later.
    assign w_rep = (r_state == HELD) && (r_rep == RW'(RPC - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state != HELD))
            r_rep <= '0;
        else
            r_rep <= w_rep ? '0 : r_rep + RW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_key_repeat <= 1'b0;
        else
            r_key_repeat <= w_rep & ~w_release;
    end

    assign key_repeat = r_key_repeat;
`else
    assign key_repeat = 1'b0;
`endif

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_click = r_dbl;
    assign busy         = r_busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gestures plus random flag traffic against a deadline-based reference model.
module tb_key_event_decoder;

    localparam int FREQ = 100_000;
    localparam int C    = 100;
    localparam int L    = 20;
    localparam int D    = 10;
    localparam int R    = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam int M_IDLE = 0, M_P1 = 1, M_HELD = 2, M_W2 = 3, M_DONE = 4;

    logic clk = 1'b0, rst = 1'b1, key_flag = 1'b0, key_state = 1'b1;
    logic short_press, long_press, double_click, key_repeat, busy;

    key_event_decoder #(
        .CLK_FREQ_HZ (FREQ),
        .LONG_MS     (L),
        .DCLICK_MS   (D),
        .REPEAT_MS   (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .key_state    (key_state),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .key_repeat   (key_repeat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    string scen = "reset";
    int m_mode = M_IDLE, m_due = 0, m_rdue = 0;
    logic [4:0] m_exp = '0;
    int n_short, n_long, n_dbl, n_rep;
    int t_short, t_long, t_dbl, t_flag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: each gesture arms an absolute deadline; outputs are predicted for cycle c+1.
    task automatic model(input int c, input logic f, input logic s, input logic r);
        logic p, rl, sh, lo, db, rp;
        p = f & ~s;
        rl = f & s;
        {sh, lo, db, rp} = '0;
        if (r) m_mode = M_IDLE;
        else case (m_mode)
            M_IDLE: if (p) begin m_mode = M_P1; m_due = c + L * C; end
            M_P1: if (c + 1 == m_due) begin
                lo = 1'b1;
                m_mode = rl ? M_IDLE : M_HELD;
                m_rdue = m_due + R * C;
            end else if (rl) begin
                m_mode = M_W2;
                m_due = c + D * C;
            end
            M_HELD: if (rl) m_mode = M_IDLE;
                else if (REP && c + 1 == m_rdue) begin rp = 1'b1; m_rdue += R * C; end
            M_W2: if (p) begin db = 1'b1; m_mode = M_DONE; end
                else if (c + 1 == m_due) begin sh = 1'b1; m_mode = M_IDLE; end
            M_DONE: if (rl) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        m_exp = {sh, lo, db, rp, m_mode != M_IDLE};
    endtask

    task automatic step(input logic f, input logic s, input logic r);
        key_flag = f;
        key_state = s;
        rst = r;
        model(cyc, f, s, r);
        @(posedge clk);
        #1;
        cyc++;
        check({scen, " outputs"}, {27'd0, short_press, long_press, double_click, key_repeat, busy}, {27'd0, m_exp});
        if (short_press === 1'b1) begin n_short++; t_short = cyc; end
        if (long_press === 1'b1) begin n_long++; t_long = cyc; end
        if (double_click === 1'b1) begin n_dbl++; t_dbl = cyc; end
        if (key_repeat === 1'b1) n_rep++;
    endtask

    task automatic flag(input logic s);
        t_flag = cyc;
        step(1'b1, s, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, key_state, 1'b0);
    endtask

    task automatic begin_scen(input string name);
        scen = name;
        {n_short, n_long, n_dbl, n_rep} = '0;
        {t_short, t_long, t_dbl} = '0;
    endtask

    initial begin
        int t0, t1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("reset outputs", {27'd0, short_press, long_press, double_click, key_repeat, busy}, 32'd0);
        idle(5);

        begin_scen("short");
        flag(1'b0); idle(200); flag(1'b1); t0 = t_flag; idle(D * C + 5);
        check("short count", n_short, 1);
        check("short time", t_short, t0 + D * C);
        check("short others", n_long + n_dbl + n_rep, 0);

        begin_scen("long");
        flag(1'b0); t0 = t_flag; idle(3200); flag(1'b1); idle(20);
        check("long count", n_long, 1);
        check("long time", t_long, t0 + L * C);
        check("long repeats", n_rep, REP ? 2 : 0);
        check("long no short", n_short + n_dbl, 0);

        begin_scen("double");
        flag(1'b0); idle(300); flag(1'b1); idle(400); flag(1'b0); t1 = t_flag; idle(100); flag(1'b1); idle(D * C + 20);
        check("double count", n_dbl, 1);
        check("double time", t_dbl, t1 + 1);
        check("double others", n_short + n_long, 0);

        begin_scen("window_edge");
        flag(1'b0); idle(200); flag(1'b1); idle(D * C - 2); flag(1'b0); idle(10); flag(1'b1); idle(10);
        check("window_edge dbl", n_dbl, 1);
        check("window_edge short", n_short, 0);

        begin_scen("long_edge");
        flag(1'b0); t0 = t_flag; idle(L * C - 2); flag(1'b1); idle(R * C + 20);
        check("long_edge count", n_long, 1);
        check("long_edge time", t_long, t0 + L * C);
        check("long_edge others", n_short + n_dbl + n_rep, 0);
        check("long_edge busy", busy, 0);

        begin_scen("reset_mid");
        flag(1'b0); idle(999); step(1'b0, key_state, 1'b1);
        check("reset_mid busy", busy, 0);
        idle(499); flag(1'b1); idle(D * C + L * C);
        check("reset_mid pulses", n_short + n_long + n_dbl + n_rep, 0);

        scen = "random";
        for (int i = 0; i < 30 && n_fail < 50; i++) begin
            int g, gap;
            g = $urandom_range(0, 3);
            gap = (g == 0) ? $urandom_range(0, 20) :
                  (g == 1) ? D * C - 3 + $urandom_range(0, 2) :
                  (g == 2) ? L * C - 3 + $urandom_range(0, 2) : $urandom_range(0, 2400);
            idle(gap);
            if ($urandom_range(0, 19) == 0) step(1'b0, key_state, 1'b1);
            else flag(($urandom_range(0, 4) == 0) ? key_state : ~key_state);
        end
        idle(L * C + R * C + 10);
        flag(1'b1);
        idle(D * C + 10);
        check("final idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
